// File: rtl/quad_decoder.sv
// quad_decoder
// Quadrature encoder decoder. Channels A and B are synchronized, decoded as
// a 4x Gray sequence on {B,A} and accumulated into a signed 32-bit position.
// Illegal jumps (both bits changing at once) are counted, and a free-running
// window of 2^WINDOW_LOG2 clocks reports the net step count as SPEED.
//
// Build option: define QUAD_DECODER_FILTER_EN to add a per-channel stability
// filter. A new level is accepted only after FILTER_LEN consecutive samples.
// Without the macro the filter is absent and FILTER_LEN is ignored.
//
// Ports
//   CLOCK        in   system clock, rising edge
//   RESET        in   asynchronous active-high reset
//   A, B         in   encoder channels, asynchronous to CLOCK
//   CLEAR        in   synchronous position clear
//   POSITION     out  [31:0] signed position, 4 counts per encoder cycle
//   DIR          out  direction of last valid step, 1 = increment
//   STEP         out  one-cycle strobe per valid step
//   ERROR_COUNT  out  [7:0] illegal transitions, saturating at 255
//   SPEED        out  [15:0] signed net steps in last completed window
//   SPEED_VALID  out  one-cycle strobe when SPEED updates
module quad_decoder #(
  parameter int FILTER_LEN  = 4,
  parameter int WINDOW_LOG2 = 20
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        A,
  input  logic        B,
  input  logic        CLEAR,
  output logic [31:0] POSITION,
  output logic        DIR,
  output logic        STEP,
  output logic [7:0]  ERROR_COUNT,
  output logic [15:0] SPEED,
  output logic        SPEED_VALID
);

  logic [1:0]               r_ab_p0;
  logic [1:0]               r_ab_p1;
  logic [1:0]               r_warm;
  logic                     r_ref_vld;
  logic [1:0]               r_ref;
  logic [1:0]               w_smp;
  logic                     w_dec_en;
  logic                     w_inc;
  logic                     w_dec;
  logic                     w_err;
  logic signed [1:0]        w_delta;
  logic signed [31:0]       r_position;
  logic                     r_dir;
  logic                     r_step;
  logic [7:0]               r_err_cnt;
  logic [WINDOW_LOG2-1:0]   r_win;
  logic                     w_win_wrap;
  logic signed [15:0]       r_acc;
  logic signed [15:0]       r_speed;
  logic                     r_spd_vld;

  function automatic logic signed [15:0] sat_add16(input logic signed [15:0] acc,
                                                   input logic signed [1:0]  d);
    logic signed [16:0] sum;
    sum = {acc[15], acc} + {{15{d[1]}}, d};
    if (sum > 17'sd32767)
      return 16'sh7FFF;
    else if (sum < -17'sd32768)
      return 16'sh8000;
    else
      return sum[15:0];
  endfunction

  // ---- stage p0/p1: two-flop synchronizer on {B,A}
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_ab_p0 <= '0;
      r_ab_p1 <= '0;
    end else begin
      r_ab_p0 <= {B, A};
      r_ab_p1 <= r_ab_p0;
    end
  end

  // Decoding waits until r_ab_p1 holds a real post-reset sample, so the
  // reset value of the synchronizer never looks like a transition.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      r_warm <= '0;
    else if (r_warm != 2'd2)
      r_warm <= r_warm + 2'd1;
  end

  assign w_dec_en = (r_warm == 2'd2);

`ifdef QUAD_DECODER_FILTER_EN
  // ---- stage p2: per-channel stability filter
  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       r_filt_p2;
  logic [CNT_W-1:0] r_fcnt [2];

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_filt_p2 <= '0;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        // The first real sample seeds the filter directly, matching the
        // reference load, so a static input level is never seen as motion.
        if (w_dec_en && !r_ref_vld) begin
          r_filt_p2[i] <= r_ab_p1[i];
          r_fcnt[i]    <= '0;
        end else if (r_ab_p1[i] == r_filt_p2[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == CNT_W'(FILTER_LEN - 1)) begin
          r_filt_p2[i] <= r_ab_p1[i];
          r_fcnt[i]    <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_smp = r_filt_p2;
`else
  logic w_unused_filter_len;
  assign w_unused_filter_len = (FILTER_LEN != 0);
  assign w_smp = r_ab_p1;
`endif

  // ---- decode stage: compare sample against reference state
  always_comb begin
    w_inc = 1'b0;
    w_dec = 1'b0;
    w_err = 1'b0;
    if (w_dec_en && r_ref_vld) begin
      case ({r_ref, w_smp})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: w_inc = 1'b1;
        4'b0100, 4'b1101, 4'b1011, 4'b0010: w_dec = 1'b1;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: w_err = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_delta = w_inc ? 2'sd1 : (w_dec ? -2'sd1 : 2'sd0);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_ref      <= '0;
      r_ref_vld  <= 1'b0;
      r_position <= '0;
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_step <= w_inc | w_dec;
      if (w_dec_en) begin
        // An illegal jump also becomes the new reference.
        r_ref     <= r_ref_vld ? w_smp : r_ab_p1;
        r_ref_vld <= 1'b1;
      end
      if (w_inc | w_dec)
        r_dir <= w_inc;
      // CLEAR wins over a coincident step; STEP/DIR still report that step.
      if (CLEAR)
        r_position <= '0;
      else if (w_inc)
        r_position <= r_position + 32'sd1;
      else if (w_dec)
        r_position <= r_position - 32'sd1;
      if (w_err && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // ---- speed window: accumulate net steps, publish on counter wrap
  assign w_win_wrap = &r_win;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_win     <= '0;
      r_acc     <= '0;
      r_speed   <= '0;
      r_spd_vld <= 1'b0;
    end else begin
      r_win     <= r_win + WINDOW_LOG2'(1);
      r_spd_vld <= w_win_wrap;
      if (w_win_wrap) begin
        r_speed <= sat_add16(r_acc, w_delta);
        r_acc   <= '0;
      end else begin
        r_acc <= sat_add16(r_acc, w_delta);
      end
    end
  end

  assign POSITION    = r_position;
  assign DIR         = r_dir;
  assign STEP        = r_step;
  assign ERROR_COUNT = r_err_cnt;
  assign SPEED       = r_speed;
  assign SPEED_VALID = r_spd_vld;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder (default build, WINDOW_LOG2 = 8).
module tb_quad_decoder;
  localparam int WLOG = 8;
  localparam int WIN  = 1 << WLOG;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        A     = 1'b0;
  logic        B     = 1'b0;
  logic        CLEAR = 1'b0;
  logic [31:0] POSITION;
  logic        DIR;
  logic        STEP;
  logic [7:0]  ERROR_COUNT;
  logic [15:0] SPEED;
  logic        SPEED_VALID;

  typedef struct packed {
    logic [31:0] pos;
    logic        dir;
    int          at;
  } step_t;

  step_t       q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          nsteps = 0;
  int          t_rst  = 0;
  logic [31:0] mpos   = '0;
  logic        mdir   = 1'b0;
  int          merr   = 0;
  logic [1:0]  mref   = 2'b00;

  quad_decoder #(.FILTER_LEN(4), .WINDOW_LOG2(WLOG)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .A           (A),
    .B           (B),
    .CLEAR       (CLEAR),
    .POSITION    (POSITION),
    .DIR         (DIR),
    .STEP        (STEP),
    .ERROR_COUNT (ERROR_COUNT),
    .SPEED       (SPEED),
    .SPEED_VALID (SPEED_VALID)
  );

  always #5 CLOCK = ~CLOCK;

  initial forever begin
    @(posedge CLOCK);
    cyc++;
  end

  // Step scoreboard: every STEP pulse must match the oldest expected step.
  initial forever begin
    step_t e;
    @(negedge CLOCK);
    if (STEP === 1'b1) begin
      nsteps++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL step_unexpected cyc=%0d pos=%h dir=%b", cyc, POSITION, DIR);
      end else begin
        e = q.pop_front();
        if (POSITION !== e.pos || DIR !== e.dir || cyc != e.at) begin
          errors++;
          $display("FAIL step_match got pos=%h dir=%b cyc=%0d want pos=%h dir=%b cyc=%0d",
                   POSITION, DIR, cyc, e.pos, e.dir, e.at);
        end
      end
    end
  end

  function automatic int gidx(input logic [1:0] ba);
    case (ba)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gval(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Drive {B,A}, predict the outcome from the Gray distance, hold.
  task automatic drive(input logic [1:0] ba, input int hold);
    int    d;
    step_t e;
    d = (gidx(ba) - gidx(mref) + 4) % 4;
    if (d == 1 || d == 3) begin
      mpos  = (d == 1) ? mpos + 32'd1 : mpos - 32'd1;
      mdir  = (d == 1);
      e.pos = mpos;
      e.dir = mdir;
      e.at  = cyc + 3;
      q.push_back(e);
    end else if (d == 2) begin
      if (merr != 255) merr++;
    end
    mref   = ba;
    {B, A} = ba;
    repeat (hold) @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] ba);
    RESET  = 1'b1;
    CLEAR  = 1'b0;
    {B, A} = ba;
    repeat (3) @(posedge CLOCK);
    #1 RESET = 1'b0;
    t_rst = cyc;
    mpos  = '0;
    mdir  = 1'b0;
    merr  = 0;
    mref  = ba;
    q.delete();
    repeat (5) @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_sv(output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 2 * WIN; i++) begin
      @(negedge CLOCK);
      if (SPEED_VALID === 1'b1) begin
        at = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    do_reset(2'b00);
    checks++; if (POSITION !== 32'd0)  begin errors++; $display("FAIL reset_pos got %h want 0", POSITION); end
    checks++; if (DIR !== 1'b0)        begin errors++; $display("FAIL reset_dir got %b want 0", DIR); end
    checks++; if (STEP !== 1'b0)       begin errors++; $display("FAIL reset_step got %b want 0", STEP); end
    checks++; if (ERROR_COUNT !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", ERROR_COUNT); end
    checks++; if (SPEED !== 16'd0)     begin errors++; $display("FAIL reset_speed got %0d want 0", SPEED); end
    checks++; if (SPEED_VALID !== 1'b0) begin errors++; $display("FAIL reset_sv got %b want 0", SPEED_VALID); end
  endtask

  task automatic test_forward();
    int n0;
    n0 = nsteps;
    drive(2'b01, 10);
    drive(2'b11, 10);
    drive(2'b10, 10);
    drive(2'b00, 10);
    checks++; if (POSITION !== 32'd4)   begin errors++; $display("FAIL fwd_pos got %0d want 4", POSITION); end
    checks++; if (DIR !== 1'b1)         begin errors++; $display("FAIL fwd_dir got %b want 1", DIR); end
    checks++; if (nsteps - n0 != 4)     begin errors++; $display("FAIL fwd_steps got %0d want 4", nsteps - n0); end
    checks++; if (ERROR_COUNT !== 8'd0) begin errors++; $display("FAIL fwd_err got %0d want 0", ERROR_COUNT); end
  endtask

  task automatic test_reverse();
    int n0;
    drive(2'b10, 10);
    drive(2'b11, 10);
    drive(2'b01, 10);
    drive(2'b00, 10);
    checks++; if (POSITION !== 32'd0) begin errors++; $display("FAIL rev_pos got %0d want 0", POSITION); end
    checks++; if (DIR !== 1'b0)       begin errors++; $display("FAIL rev_dir got %b want 0", DIR); end
    n0 = nsteps;
    drive(2'b11, 10);
    checks++; if (ERROR_COUNT !== 8'(merr)) begin errors++; $display("FAIL jump_err got %0d want %0d", ERROR_COUNT, merr); end
    checks++; if (POSITION !== 32'd0) begin errors++; $display("FAIL jump_pos got %0d want 0", POSITION); end
    checks++; if (nsteps != n0)       begin errors++; $display("FAIL jump_step got %0d pulses want 0", nsteps - n0); end
    checks++; if (DIR !== 1'b0)       begin errors++; $display("FAIL jump_dir got %b want 0", DIR); end
  endtask

  task automatic test_wrap_clear();
    step_t e;
    force dut.r_position = 32'sh7FFF_FFFF;
    @(posedge CLOCK);
    #1;
    release dut.r_position;
    mpos = 32'h7FFF_FFFF;
    drive(gval(gidx(mref) + 1), 8);
    checks++; if (POSITION !== 32'h8000_0000) begin errors++; $display("FAIL wrap_up got %h want 80000000", POSITION); end
    drive(gval(gidx(mref) + 3), 8);
    checks++; if (POSITION !== 32'h7FFF_FFFF) begin errors++; $display("FAIL wrap_down got %h want 7fffffff", POSITION); end
    // Step landing on the same edge as CLEAR.
    e.pos = 32'd0;
    e.dir = 1'b1;
    e.at  = cyc + 3;
    q.push_back(e);
    mref   = gval(gidx(mref) + 1);
    {B, A} = mref;
    mpos   = '0;
    mdir   = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1 CLEAR = 1'b1;
    @(posedge CLOCK);
    #1 CLEAR = 1'b0;
    repeat (4) @(posedge CLOCK);
    #1;
    checks++; if (POSITION !== 32'd0) begin errors++; $display("FAIL clr_step_pos got %h want 0", POSITION); end
    checks++; if (DIR !== 1'b1)       begin errors++; $display("FAIL clr_step_dir got %b want 1", DIR); end
    drive(gval(gidx(mref) + 1), 6);
    drive(gval(gidx(mref) + 1), 6);
    CLEAR = 1'b1;
    @(posedge CLOCK);
    #1 CLEAR = 1'b0;
    mpos = '0;
    checks++; if (POSITION !== 32'd0) begin errors++; $display("FAIL clr_only got %h want 0", POSITION); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(gval(gidx(mref) + 1), 1);
    for (int i = 0; i < 8; i++) drive(gval(gidx(mref) + 3), 1);
    drive(gval(gidx(mref) + 3), 1);
    repeat (6) @(posedge CLOCK);
    #1;
    checks++; if (POSITION !== mpos) begin errors++; $display("FAIL b2b_pos got %h want %h", POSITION, mpos); end
    checks++; if (q.size() != 0)     begin errors++; $display("FAIL b2b_pending got %0d want 0", q.size()); end
  endtask

  task automatic test_reset_hold();
    int n0;
    n0 = nsteps;
    do_reset(2'b11);
    repeat (15) @(posedge CLOCK);
    #1;
    checks++; if (nsteps != n0)         begin errors++; $display("FAIL hold11_step got %0d pulses want 0", nsteps - n0); end
    checks++; if (ERROR_COUNT !== 8'd0) begin errors++; $display("FAIL hold11_err got %0d want 0", ERROR_COUNT); end
    checks++; if (POSITION !== 32'd0)   begin errors++; $display("FAIL hold11_pos got %h want 0", POSITION); end
  endtask

  task automatic test_speed();
    int at;
    bit ok;
    do_reset(2'b00);
    for (int i = 0; i < 10; i++) begin
      drive(gval(gidx(mref) + 1), 6);
      if (i == 4) begin
        CLEAR = 1'b1;
        @(posedge CLOCK);
        #1 CLEAR = 1'b0;
        mpos = '0;
      end
    end
    wait_sv(at, ok);
    checks++; if (!ok || at != t_rst + WIN) begin errors++; $display("FAIL win1_time got %0d want %0d", at, t_rst + WIN); end
    checks++; if (SPEED !== 16'd10) begin errors++; $display("FAIL win1_speed got %0d want 10", SPEED); end
    checks++; if (POSITION !== mpos) begin errors++; $display("FAIL win1_pos got %0d want %0d", POSITION, mpos); end
    @(negedge CLOCK);
    checks++; if (SPEED_VALID !== 1'b0) begin errors++; $display("FAIL sv_width got %b want 0", SPEED_VALID); end
    wait_sv(at, ok);
    checks++; if (!ok || at != t_rst + 2 * WIN) begin errors++; $display("FAIL win2_time got %0d want %0d", at, t_rst + 2 * WIN); end
    checks++; if (SPEED !== 16'd0) begin errors++; $display("FAIL win2_speed got %0d want 0", SPEED); end
    @(posedge CLOCK);
    #1;
    for (int i = 0; i < 3; i++) drive(gval(gidx(mref) + 1), 6);
    drive(gval(gidx(mref) + 2), 6);
    wait_sv(at, ok);
    checks++; if (!ok || at != t_rst + 3 * WIN) begin errors++; $display("FAIL win3_time got %0d want %0d", at, t_rst + 3 * WIN); end
    checks++; if (SPEED !== 16'd3) begin errors++; $display("FAIL win3_speed got %0d want 3", SPEED); end
    checks++; if (ERROR_COUNT !== 8'(merr)) begin errors++; $display("FAIL win3_err got %0d want %0d", ERROR_COUNT, merr); end
    // Asynchronous reset between clock edges.
    #2 RESET = 1'b1;
    #1;
    checks++; if (POSITION !== 32'd0)   begin errors++; $display("FAIL async_pos got %h want 0", POSITION); end
    checks++; if (DIR !== 1'b0)         begin errors++; $display("FAIL async_dir got %b want 0", DIR); end
    checks++; if (ERROR_COUNT !== 8'd0) begin errors++; $display("FAIL async_err got %0d want 0", ERROR_COUNT); end
    checks++; if (SPEED !== 16'd0)      begin errors++; $display("FAIL async_speed got %0d want 0", SPEED); end
    checks++; if (SPEED_VALID !== 1'b0) begin errors++; $display("FAIL async_sv got %b want 0", SPEED_VALID); end
    checks++; if (STEP !== 1'b0)        begin errors++; $display("FAIL async_step got %b want 0", STEP); end
    @(posedge CLOCK);
    #1 RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_wrap_clear();
    test_back_to_back();
    test_reset_hold();
    test_speed();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL steps_missing got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 4: cycles A/B must hold stable before acceptance (filter build only).
REQ-002 The block SHALL have parameter WINDOW_LOG2, default 20: speed window length is 2^WINDOW_LOG2 CLOCK cycles.
REQ-003 The block SHALL have port CLOCK  input  1  system clock; all state on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port A  input  1  encoder channel A, asynchronous to CLOCK.
REQ-006 The block SHALL have port B  input  1  encoder channel B, asynchronous to CLOCK.
REQ-007 The block SHALL have port CLEAR  input  1  synchronous position clear.
REQ-008 The block SHALL have port POSITION  output  32  signed position count, 4 counts per encoder cycle.
REQ-009 The block SHALL have port DIR  output  1  direction of last valid step, 1 = increment.
REQ-010 The block SHALL have port STEP  output  1  one-cycle strobe on every valid step.
REQ-011 The block SHALL have port ERROR_COUNT  output  8  illegal transitions seen, saturating.
REQ-012 The block SHALL have port SPEED  output  16  signed net steps in the last completed window.
REQ-013 The block SHALL have port SPEED_VALID  output  1  one-cycle strobe when SPEED updates.

Function
REQ-014 A and B SHALL each pass a 2-flop synchronizer before any use.
REQ-015 Sampled state SHALL be {B,A}; increment transitions: 00->01, 01->11, 11->10, 10->00; the reverse four SHALL decrement.
REQ-016 A valid step SHALL update POSITION, set DIR and pulse STEP on the same edge, 3 CLOCK edges after the input change (no-filter build).
REQ-017 An unchanged sample SHALL cause no step and leave DIR unchanged.
REQ-018 A sample with both bits changed SHALL leave POSITION and DIR unchanged, raise no STEP, increment ERROR_COUNT (hold at 255) and become the new reference state.
REQ-019 POSITION SHALL wrap two's complement: 0x7FFFFFFF +1 -> 0x80000000; 0x80000000 -1 -> 0x7FFFFFFF.
REQ-020 CLEAR SHALL set POSITION to 0 on the next edge; a step coincident with CLEAR SHALL be discarded for POSITION but STEP and DIR SHALL still reflect it.
REQ-021 A free-running window counter SHALL count from 0 to 2^WINDOW_LOG2-1 and wrap.
REQ-022 A 16-bit signed accumulator SHALL add +1/-1 per valid step, saturating at +32767 / -32768.
REQ-023 On the window-wrap cycle SHALL SPEED load the accumulator including that cycle's step, SPEED_VALID pulse one cycle, and the accumulator restart at 0.
REQ-024 CLEAR SHALL NOT affect SPEED, the accumulator or the window counter.

Reset
REQ-025 RESET SHALL asynchronously clear POSITION, DIR, STEP, ERROR_COUNT, SPEED, SPEED_VALID, accumulator, window counter, synchronizers and filter state to 0.
REQ-026 The first decoded sample after RESET deassertion SHALL only load the reference state, with no step and no error, whatever the A/B level.
REQ-027 RESET asserted mid-window SHALL discard the partial window; the first SPEED_VALID SHALL follow 2^WINDOW_LOG2 cycles after deassertion.

Configuration
REQ-028 With macro QUAD_DECODER_FILTER_EN defined, each synchronized channel SHALL be accepted only after holding a new level for FILTER_LEN consecutive cycles; shorter pulses SHALL be ignored; latency becomes 3+FILTER_LEN edges.
REQ-029 Without QUAD_DECODER_FILTER_EN the filter SHALL be absent and FILTER_LEN unused.

Verification
REQ-030 Reset, then drive {B,A} 00,01,11,10,00 each held 10 cycles -> POSITION 4, DIR 1, four STEP pulses, ERROR_COUNT 0.
REQ-031 Reverse sequence 00,10,11,01,00 from POSITION 4 -> POSITION 0, DIR 0; then jump 00->11 -> ERROR_COUNT 1, POSITION 0, no STEP.
REQ-032 Force POSITION to 0x7FFFFFFF by stepping or preload, one increment -> 0x80000000; assert CLEAR coincident with a step -> POSITION 0, STEP 1.
REQ-033 WINDOW_LOG2=8, 10 increments inside one window -> SPEED_VALID at cycle 256 with SPEED 10; next window with no motion -> SPEED 0.
REQ-034 Filter build, FILTER_LEN 4: 2-cycle glitch on A -> no STEP; 6-cycle level change -> one STEP at edge 7 after the change.
REQ-035 Hold A=1, B=1 through RESET release -> no STEP and ERROR_COUNT 0; assert RESET mid-count -> all outputs 0 immediately, without waiting for a CLOCK edge.
